// File: rtl/alu_pipe_if.sv
// rtl/alu_pipe_if.sv - issue/result handshake bundle for alu_pipe
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, alu_op, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, alu_op, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result; ALU_MULDIV_EN adds iterative MUL/MULH/DIVU/REMU
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  alu_pipe_if.slave  bus
);
  localparam int SH = $clog2(WIDTH);

  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] alu_res;
  logic [SH-1:0]    shamt;
  logic             accept;

  assign shamt  = bus.a[SH-1:0];
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_res = '0;
    case (bus.alu_op)
      4'd0:    alu_res = bus.a + bus.b;
      4'd1:    alu_res = bus.a - bus.b;
      4'd2:    alu_res = bus.a & bus.b;
      4'd3:    alu_res = bus.a | bus.b;
      4'd4:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'd5:    alu_res = bus.b << shamt;
      4'd6:    alu_res = bus.b >> shamt;
      4'd7:    alu_res = WIDTH'($signed(bus.b) >>> shamt);
      4'd8:    alu_res = bus.a ^ bus.b;
`ifdef ALU_MULDIV_EN
      // Only reached for a zero divisor; non-zero divisors go to the sequencer.
      4'd11:   alu_res = '1;
      4'd12:   alu_res = bus.a;
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               hi_q, hi_d;
  logic [SH:0]        cnt_q, cnt_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next;

  // acc holds {high product, multiplier} for MUL and {remainder, quotient} for DIV.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd_q});
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  assign bus.in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
`ifdef ALU_MULDIV_EN
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.alu_op == 4'd9 || bus.alu_op == 4'd10) begin
            state_d = S_MUL;
            opnd_d  = bus.a;
            acc_d   = {{WIDTH{1'b0}}, bus.b};
            hi_d    = (bus.alu_op == 4'd10);
            cnt_d   = (SH+1)'(WIDTH);
          end else if ((bus.alu_op == 4'd11 || bus.alu_op == 4'd12) && bus.b != '0) begin
            state_d = S_DIV;
            opnd_d  = bus.b;
            acc_d   = {{WIDTH{1'b0}}, bus.a};
            hi_d    = (bus.alu_op == 4'd12);
            cnt_d   = (SH+1)'(WIDTH);
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        acc_d = (state_q == S_MUL) ? mul_next : div_next;
        cnt_d = cnt_q - (SH+1)'(1);
        if (cnt_q == (SH+1)'(1)) begin
          result_d    = hi_q ? acc_d[2*WIDTH-1:WIDTH] : acc_d[WIDTH-1:0];
          zero_d      = (result_d == '0);
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`else
    if (accept) begin
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      out_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      state_q     <= S_IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      hi_q        <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_MULDIV_EN
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed vector bench for alu_pipe (expectations follow ALU_MULDIV_EN)
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(16)) bus ();

  alu_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] res, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.z = (res == 16'h0); v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk(name, {31'b0, bus.in_ready}, 32'h1);
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1;
    bus.alu_op   = op;
    bus.a        = a;
    bus.b        = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic busy_ready;
    logic unstable;

    add(4'd0, 16'hFFFF, 16'h0001, 16'h0000, 0);
    add(4'd1, 16'h0005, 16'h0003, 16'h0002, 0);
    add(4'd2, 16'hFF00, 16'h0F0F, 16'h0F00, 0);
    add(4'd3, 16'hFF00, 16'h00FF, 16'hFFFF, 0);
    add(4'd8, 16'hFFFF, 16'h0F0F, 16'hF0F0, 0);
    add(4'd5, 16'h0004, 16'h0001, 16'h0010, 0);
    add(4'd7, 16'h0004, 16'h8000, 16'hF800, 0);
    add(4'd6, 16'h0004, 16'h8000, 16'h0800, 0);
    add(4'd4, 16'hFFFF, 16'h0001, 16'h0001, 0);
    add(4'd4, 16'h0001, 16'hFFFF, 16'h0000, 0);
    add(4'd5, 16'hFFF3, 16'h0001, 16'h0008, 0);
    add(4'd7, 16'h000F, 16'h4000, 16'h0000, 0);
    add(4'd13, 16'h0005, 16'h0005, 16'h0000, 0);
    add(4'd15, 16'hFFFF, 16'hFFFF, 16'h0000, 0);
`ifdef ALU_MULDIV_EN
    add(4'd9,  16'd300,  16'd300,  16'h5F90, 16);
    add(4'd10, 16'd300,  16'd300,  16'h0001, 16);
    add(4'd9,  16'hFFFF, 16'hFFFF, 16'h0001, 16);
    add(4'd10, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16);
    add(4'd11, 16'd100,  16'd7,    16'h000E, 16);
    add(4'd12, 16'd100,  16'd7,    16'h0002, 16);
    add(4'd11, 16'hFFFF, 16'h0001, 16'hFFFF, 16);
    add(4'd12, 16'd6,    16'd7,    16'h0006, 16);
    add(4'd11, 16'd9,    16'd0,    16'hFFFF, 0);
    add(4'd12, 16'd9,    16'd0,    16'h0009, 0);
`else
    add(4'd9,  16'd300,  16'd300,  16'h0000, 0);
    add(4'd10, 16'd300,  16'd300,  16'h0000, 0);
    add(4'd11, 16'd100,  16'd7,    16'h0000, 0);
    add(4'd12, 16'd100,  16'd7,    16'h0000, 0);
    add(4'd11, 16'd9,    16'd0,    16'h0000, 0);
    add(4'd12, 16'd9,    16'd0,    16'h0000, 0);
`endif

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op    = 4'd0;
    bus.a         = 16'h0;
    bus.b         = 16'h0;
    step();
    step();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_result", {16'b0, bus.result}, 32'h0);
    chk("rst_zero", {31'b0, bus.zero}, 32'h1);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    rst = 1'b0;

    // Consecutive vectors are offered on consecutive edges while out_ready is high.
    foreach (vecs[i]) begin
      wait_ready($sformatf("v%0d_in_ready", i));
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      n = 0;
      busy_ready = 1'b0;
      while (!bus.out_valid && n < 40) begin
        if (bus.in_ready) busy_ready = 1'b1;
        step();
        n++;
      end
      chk($sformatf("v%0d_op%0d_latency", i, vecs[i].op), n, vecs[i].lat);
      chk($sformatf("v%0d_op%0d_result", i, vecs[i].op), {16'b0, bus.result}, {16'b0, vecs[i].res});
      chk($sformatf("v%0d_op%0d_zero", i, vecs[i].op), {31'b0, bus.zero}, {31'b0, vecs[i].z});
      if (vecs[i].lat > 0)
        chk($sformatf("v%0d_busy_in_ready", i), {31'b0, busy_ready}, 32'h0);
    end
    step();
    chk("drain_out_valid", {31'b0, bus.out_valid}, 32'h0);

    // Backpressure: result held, then retire and accept in the same cycle.
    bus.out_ready = 1'b0;
    wait_ready("bp_in_ready");
    issue(4'd0, 16'h0002, 16'h0003);
    chk("bp_out_valid", {31'b0, bus.out_valid}, 32'h1);
    unstable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (bus.result !== 16'h0005 || bus.zero !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0)
        unstable = 1'b1;
    end
    chk("bp_stall_stable", {31'b0, unstable}, 32'h0);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'd2;
    bus.a         = 16'hFF00;
    bus.b         = 16'h0F0F;
    #1;
    chk("bp_release_in_ready", {31'b0, bus.in_ready}, 32'h1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_and_result", {16'b0, bus.result}, 32'h0F00);
    chk("bp_and_out_valid", {31'b0, bus.out_valid}, 32'h1);
    step();
    chk("bp_retired", {31'b0, bus.out_valid}, 32'h0);

    // Reset five cycles into a DIVU aborts it and any pending result.
    bus.out_ready = 1'b0;
    wait_ready("rd_in_ready");
    issue(4'd11, 16'd100, 16'd7);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rd_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rd_result", {16'b0, bus.result}, 32'h0);
    chk("rd_zero", {31'b0, bus.zero}, 32'h1);
    chk("rd_in_ready", {31'b0, bus.in_ready}, 32'h1);
    bus.out_ready = 1'b1;
    issue(4'd0, 16'h0001, 16'h0001);
    chk("rd_add_out_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("rd_add_result", {16'b0, bus.result}, 32'h0002);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 16-bit combinational ALU in the microRISC execute stage. It adds a registered output with valid/ready flow control, an arithmetic right shift, XOR, and iterative unsigned multiply/divide. Single-cycle operations take one cycle. MUL/DIV operations run a WIDTH-step sequencer while the block back-pressures the issue logic.

## Interface
- WIDTH, 16, datapath width; power of two, ≥ 8; SH = $clog2(WIDTH)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept an operation this cycle
- alu_op  in  4  opcode, sampled on accept
- a  in  WIDTH  operand A / shift amount source
- b  in  WIDTH  operand B / shift value source
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes the result this cycle
- result  out  WIDTH  registered result
- zero  out  1  registered, result == 0

## Operation
- Opcodes:
  - 0 ADD a+b, mod 2^WIDTH
  - 1 SUB a−b, mod 2^WIDTH
  - 2 AND
  - 3 OR
  - 4 SLT: a<b signed → 1, else 0
  - 5 SLL b<<a[SH-1:0]
  - 6 SRL b>>a[SH-1:0] logical
  - 7 SRA b>>>a[SH-1:0] arithmetic
  - 8 XOR
  - 9 MUL, low WIDTH bits of unsigned a*b
  - 10 MULH, high WIDTH bits of unsigned a*b
  - 11 DIVU a/b
  - 12 REMU a%b
  - 13–15 reserved: result 0, zero 1, single-cycle
- Shift amount comes from a, shifted value from b; upper bits of a are ignored.
- DIVU by 0 → all-ones; REMU by 0 → a.
- FSM states: IDLE, MUL, DIV.
  - IDLE, single-cycle op accepted: result registered at the same edge; remain IDLE.
  - IDLE, op 9/10 accepted: load a, b, 2·WIDTH-bit product accumulator, step counter = WIDTH; go to MUL.
  - IDLE, op 11/12 accepted: load a, b, quotient/remainder, step counter = WIDTH; go to DIV.
  - MUL: shift-add, one bit per cycle. When the counter hits 0, write the selected half to result, set out_valid, go to IDLE.
  - DIV: restoring, one quotient bit per cycle. Finish as in MUL; zero divisor is detected at accept and completes in one cycle.
- Accept = in_valid && in_ready.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- out_valid set on completion; cleared when out_valid && out_ready and no new completion lands on that edge.
- result/zero stay stable while out_valid && !out_ready.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, zero 1, in_ready 1 (combinational from state), counters 0.
- Single-cycle ops: accept at edge N, out_valid high after edge N. Back-to-back throughput of 1/cycle while out_ready is high.
- MUL/MULH/DIVU/REMU with b≠0: accept at edge N, out_valid high after edge N+WIDTH. in_ready stays low from N through N+WIDTH.
- DIVU/REMU with b==0: behave as single-cycle ops.
- Same cycle out_valid && out_ready && in_valid in IDLE:
  - old result retires;
  - new op is accepted;
  - single-cycle ops leave out_valid high with the new result.
- rst mid-MUL/DIV aborts the operation and any pending result: IDLE and out_valid 0 on the next edge.
- in_valid while in_ready is low is ignored; the operand inputs carry no hold requirement.

## Configuration
- ALU_MULDIV_EN defined: opcodes 9–12 are implemented as above, with MUL/DIV states and the sequencer datapath compiled in.
- ALU_MULDIV_EN undefined:
  - no sequencer or MUL/DIV states in the netlist;
  - opcodes 9–12 behave as reserved (single-cycle, result 0, zero 1);
  - in_ready depends only on out_valid/out_ready.

## Test plan
All scenarios use WIDTH=16.
- ADD a=0xFFFF, b=0x0001 → result 0x0000, zero 1, out_valid one cycle after accept. Then SUB 5−3 → 0x0002, zero 0, issued back-to-back with out_ready held high.
- Shifts with a=4: SLL b=0x0001 → 0x0010; SRA b=0x8000 → 0xF800; SRL b=0x8000 → 0x0800. SLT a=0xFFFF, b=0x0001 → 1 (signed).
- With ALU_MULDIV_EN:
  - MUL a=300, b=300 → 0x5F90;
  - MULH same operands → 0x0001;
  - out_valid exactly 16 edges after accept;
  - in_ready low throughout.
- DIVU 100/7 → 0x000E and REMU 100/7 → 0x0002, each with 16-cycle latency. DIVU 9/0 → 0xFFFF and REMU 9/0 → 0x0009, each with 1-cycle latency.
- Backpressure: hold out_ready low for 5 cycles after an ADD completes → result/zero stable, in_ready low. Then raise out_ready with in_valid (AND 0xFF00, 0x0F0F) in the same cycle → 0x0F00 on the next cycle with no bubble.
- Assert rst 5 cycles into DIVU → next cycle state IDLE, out_valid 0, result 0, in_ready 1. A subsequent ADD 1+1 returns 0x0002.
